// File: rtl/hsv_core_pkg.sv
// Shared ALU payload types and the default ALU pipeline depth.
package hsv_core_pkg;

  localparam int ALU_STAGES_DEFAULT = 3;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [7:0]  tag;
    logic [15:0] src_a;
    logic [15:0] src_b;
  } alu_data_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [15:0] value;
  } alu_result_t;

endpackage

// File: rtl/hsv_core_alu_result_fifo.sv
// In-order result FIFO between the last ALU stage and commit.
// Payload storage is left unreset; only pointers and count are reset or cleared.
module hsv_core_alu_result_fifo
  import hsv_core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        clr,
  input  logic        push,
  input  alu_result_t wdata,
  input  logic        pop,
  output alu_result_t rdata,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);

  alu_result_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_core) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hsv_core_alu_issue_ctrl.sv
// ALU issue control: credit-gated dispatch, in-order result FIFO towards commit,
// and a flush sequencer that drains the unstallable ALU stages after flush or reset.
module hsv_core_alu_issue_ctrl
  import hsv_core_pkg::*;
#(
  parameter  int ALU_STAGES = ALU_STAGES_DEFAULT,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_core,
  input  logic          rst_core_n,
  input  logic          flush_req,
  input  logic          alu_valid_i,
  input  alu_data_t     in_alu_data,
  output logic          alu_ready_o,
  output logic          setup_valid_o,
  output alu_data_t     setup_alu_data,
  output logic          pipe_flush_o,
  input  logic          result_valid_i,
  input  alu_result_t   result_i,
  output logic          commit_valid_o,
  output alu_result_t   commit_result_o,
  input  logic          commit_ready_i,
  output logic [CW-1:0] credits_o
);

  localparam int FW = $clog2(ALU_STAGES + 1);

  // state | meaning
  // RUN   | dispatch, result capture and commit enabled
  // FLUSH | ALU stages draining; results ignored, no dispatch or commit
  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] credits;
  logic          run;
  logic          fire;
  logic          pop;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full;

  assign run             = (state == RUN);
  assign alu_ready_o     = run & (credits != '0) & ~flush_req;
  assign fire            = alu_valid_i & alu_ready_o;
  assign setup_valid_o   = fire;
  assign setup_alu_data  = in_alu_data;
  assign pipe_flush_o    = flush_req | ~run;
  assign commit_valid_o  = ~fifo_empty & run & ~flush_req;
  assign pop             = commit_valid_o & commit_ready_i;
  assign push            = result_valid_i & run & ~flush_req;
  assign credits_o       = credits;

  // A credit covers an op from dispatch until its result leaves the FIFO.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state     <= FLUSH;
      flush_cnt <= FW'(ALU_STAGES);
      credits   <= CW'(FIFO_DEPTH);
    end else if (flush_req) begin
      state     <= FLUSH;
      flush_cnt <= FW'(ALU_STAGES);
      credits   <= CW'(FIFO_DEPTH);
    end else if (state == RUN) begin
      if (fire && !pop)      credits <= credits - CW'(1);
      else if (pop && !fire) credits <= credits + CW'(1);
    end else begin
      flush_cnt <= flush_cnt - FW'(1);
      if (flush_cnt == FW'(1)) state <= RUN;
    end
  end

  hsv_core_alu_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .clr        (flush_req),
    .push       (push),
    .wdata      (result_i),
    .pop        (pop),
    .rdata      (commit_result_o),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  credits_in_range: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    credits <= CW'(FIFO_DEPTH));

  no_push_when_full: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    !(push && fifo_full));

endmodule

// File: tb/tb_hsv_core_alu_issue_ctrl.sv
// Bench for hsv_core_alu_issue_ctrl: directed scenarios plus random traffic against a
// queue-based reference model, with a lazy 3-stage ALU pipe modelled around the DUT.
module tb_hsv_core_alu_issue_ctrl;
  import hsv_core_pkg::*;

  localparam int STG = 3;
  localparam int FD  = 4;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        flush_req;
  logic        alu_valid_i;
  alu_data_t   in_alu_data;
  logic        alu_ready_o;
  logic        setup_valid_o;
  alu_data_t   setup_alu_data;
  logic        pipe_flush_o;
  logic        result_valid_i;
  alu_result_t result_i;
  logic        commit_valid_o;
  alu_result_t commit_result_o;
  logic        commit_ready_i;
  logic [2:0]  credits_o;

  int checks = 0;
  int errors = 0;

  alu_result_t m_q[$];
  int          m_credits;
  int          m_left;
  bit          m_run;

  logic        pipe_v[STG];
  alu_data_t   pipe_d[STG];

  logic        last_pf, last_ready, last_cv;
  int          last_credits;
  logic [7:0]  popped[$];

  hsv_core_alu_issue_ctrl #(.ALU_STAGES(STG), .FIFO_DEPTH(FD)) dut (
    .clk_core        (clk_core),
    .rst_core_n      (rst_core_n),
    .flush_req       (flush_req),
    .alu_valid_i     (alu_valid_i),
    .in_alu_data     (in_alu_data),
    .alu_ready_o     (alu_ready_o),
    .setup_valid_o   (setup_valid_o),
    .setup_alu_data  (setup_alu_data),
    .pipe_flush_o    (pipe_flush_o),
    .result_valid_i  (result_valid_i),
    .result_i        (result_i),
    .commit_valid_o  (commit_valid_o),
    .commit_result_o (commit_result_o),
    .commit_ready_i  (commit_ready_i),
    .credits_o       (credits_o)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic alu_result_t alu_fn(input alu_data_t d);
    alu_result_t r;
    r.tag   = d.tag;
    r.value = d.src_a + d.src_b;
    return r;
  endfunction

  function automatic alu_data_t rand_op(input logic [7:0] tag);
    alu_data_t d;
    d.opcode = 4'($urandom);
    d.tag    = tag;
    d.src_a  = 16'($urandom);
    d.src_b  = 16'($urandom);
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at negedge, advance model, then advance the ALU pipe.
  task automatic step();
    logic      exp_ready, exp_cv, exp_fire, pop, push, sv_v;
    alu_data_t sv_d;
    @(negedge clk_core);
    exp_ready = m_run && (m_credits > 0) && !flush_req;
    exp_cv    = m_run && (m_q.size() > 0) && !flush_req;
    exp_fire  = alu_valid_i && exp_ready;
    check("alu_ready", 64'(alu_ready_o), 64'(exp_ready));
    check("setup_valid", 64'(setup_valid_o), 64'(exp_fire));
    check("setup_data", 64'(setup_alu_data), 64'(in_alu_data));
    check("pipe_flush", 64'(pipe_flush_o), 64'(flush_req || !m_run));
    check("credits", 64'(credits_o), 64'(m_credits));
    check("commit_valid", 64'(commit_valid_o), 64'(exp_cv));
    if (exp_cv) check("commit_head", 64'(commit_result_o), 64'(m_q[0]));
    last_pf      = pipe_flush_o;
    last_ready   = alu_ready_o;
    last_cv      = commit_valid_o;
    last_credits = int'(credits_o);
    if (commit_valid_o && commit_ready_i) popped.push_back(commit_result_o.tag);
    pop  = exp_cv && commit_ready_i;
    push = m_run && !flush_req && result_valid_i;
    sv_v = setup_valid_o;
    sv_d = setup_alu_data;
    if (rst_core_n) begin
      if (flush_req) begin
        m_q.delete();
        m_credits = FD;
        m_left    = STG;
        m_run     = 0;
      end else if (m_run) begin
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(result_i);
        m_credits = m_credits - int'(exp_fire) + int'(pop);
      end else begin
        m_left--;
        if (m_left == 0) m_run = 1;
      end
    end
    @(posedge clk_core);
    #1;
    for (int i = STG - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0]      = sv_v;
    pipe_d[0]      = sv_d;
    result_valid_i = pipe_v[STG-1];
    result_i       = alu_fn(pipe_d[STG-1]);
  endtask

  task automatic apply_reset(input int cycles);
    rst_core_n = 1'b0;
    #1;
    check("rst_pipe_flush", 64'(pipe_flush_o), 64'(1));
    check("rst_credits", 64'(credits_o), 64'(FD));
    check("rst_ready", 64'(alu_ready_o), 64'(0));
    check("rst_commit_valid", 64'(commit_valid_o), 64'(0));
    m_q.delete();
    m_credits = FD;
    m_left    = STG;
    m_run     = 0;
    repeat (cycles) step();
    rst_core_n = 1'b1;
  endtask

  // Counts consecutive pipe_flush cycles (bounded), stopping at the first RUN cycle.
  task automatic count_pf(output int n, output int nrl);
    n   = 0;
    nrl = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (!last_pf) break;
      n++;
      if (!last_ready) nrl++;
    end
  endtask

  initial begin
    int n, nrl;
    logic pf1, rdy1;
    rst_core_n     = 1'b1;
    flush_req      = 1'b0;
    alu_valid_i    = 1'b0;
    in_alu_data    = '0;
    commit_ready_i = 1'b0;
    result_valid_i = 1'b0;
    result_i       = '0;
    for (int i = 0; i < STG; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    #2;
    apply_reset(2);

    // Reset release: exactly STG drain cycles, then ready with full credits.
    count_pf(n, nrl);
    check("reset_pf_cycles", 64'(n), 64'(STG));
    check("reset_ready_after", 64'(last_ready), 64'(1));
    check("reset_credits_after", 64'(last_credits), 64'(FD));

    // Credit exhaustion.
    alu_valid_i = 1'b1;
    for (int i = 0; i < FD; i++) begin
      in_alu_data = rand_op(8'(8'h10 + i));
      step();
    end
    step();
    check("exhaust_credits", 64'(last_credits), 64'(0));
    check("exhaust_ready", 64'(last_ready), 64'(0));
    alu_valid_i = 1'b0;
    repeat (4) step();
    check("exhaust_commit_valid", 64'(last_cv), 64'(1));

    // Credit recovery, then simultaneous fire and pop.
    commit_ready_i = 1'b1;
    step();
    commit_ready_i = 1'b0;
    step();
    check("recover_credits", 64'(last_credits), 64'(1));
    check("recover_ready", 64'(last_ready), 64'(1));
    alu_valid_i    = 1'b1;
    commit_ready_i = 1'b1;
    in_alu_data    = rand_op(8'h20);
    step();
    alu_valid_i    = 1'b0;
    commit_ready_i = 1'b0;
    step();
    check("fire_pop_credits", 64'(last_credits), 64'(1));

    commit_ready_i = 1'b1;
    repeat (10) step();

    // Ordering with random commit back-pressure.
    popped.delete();
    alu_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_alu_data    = rand_op(8'(8'h0A + i));
      commit_ready_i = 1'($urandom);
      step();
    end
    alu_valid_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      commit_ready_i = (i >= 14) ? 1'b1 : 1'($urandom);
      step();
    end
    check("order_count", 64'(popped.size()), 64'(4));
    for (int i = 0; i < 4 && i < popped.size(); i++)
      check("order_tag", 64'(popped[i]), 64'(8'h0A + i));

    // Mid-flight flush: two queued, two in flight.
    commit_ready_i = 1'b0;
    alu_valid_i    = 1'b1;
    repeat (2) begin
      in_alu_data = rand_op(8'($urandom));
      step();
    end
    alu_valid_i = 1'b0;
    repeat (4) step();
    alu_valid_i = 1'b1;
    repeat (2) begin
      in_alu_data = rand_op(8'($urandom));
      step();
    end
    alu_valid_i = 1'b0;
    flush_req   = 1'b1;
    step();
    pf1       = last_pf;
    rdy1      = last_ready;
    flush_req = 1'b0;
    count_pf(n, nrl);
    check("flush_pf_pulse", 64'(pf1), 64'(1));
    check("flush_ready_pulse", 64'(rdy1), 64'(0));
    check("flush_pf_cycles", 64'(n), 64'(STG));
    check("flush_ready_low_cycles", 64'(nrl), 64'(STG));
    check("flush_credits", 64'(last_credits), 64'(FD));
    check("flush_fifo_empty", 64'(last_cv), 64'(0));
    repeat (3) step();

    // Back-to-back flush while flush_cnt is 1.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (STG - 1) step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    count_pf(n, nrl);
    check("b2b_pf_cycles", 64'(n), 64'(STG));

    // Random traffic with occasional flushes and one async reset.
    for (int i = 0; i < 400; i++) begin
      alu_valid_i    = ($urandom_range(0, 9) < 6);
      in_alu_data    = rand_op(8'($urandom));
      commit_ready_i = ($urandom_range(0, 3) != 0);
      flush_req      = ($urandom_range(0, 23) == 0);
      if (i == 200) begin
        flush_req = 1'b0;
        apply_reset(2);
      end else begin
        step();
      end
    end
    flush_req      = 1'b0;
    alu_valid_i    = 1'b0;
    commit_ready_i = 1'b1;
    repeat (12) step();
    check("final_credits", 64'(last_credits), 64'(FD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsv_core_alu_issue_ctrl.md
HSV_CORE_ALU_ISSUE_CTRL -- requirements
Module: hsv_core_alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock, clk_core, and an asynchronous, active-low reset, rst_core_n.
REQ-002 Parameter ALU_STAGES, default 3: pipeline depth from setup input to result output; legal values are 1 or more.
REQ-003 Parameter FIFO_DEPTH, default 4: result FIFO entries; power of two, 2 or more.
REQ-004 clk_core  in  1  core clock.
REQ-005 rst_core_n  in  1  asynchronous active-low reset.
REQ-006 flush_req  in  1  core-wide flush.
REQ-007 alu_valid_i  in  1  dispatch offers an ALU op.
REQ-008 in_alu_data  in  alu_data_t  dispatched op.
REQ-009 alu_ready_o  out  1  op accepted this cycle.
REQ-010 setup_valid_o  out  1  valid into the bitwise setup stage.
REQ-011 setup_alu_data  out  alu_data_t  op into the bitwise setup stage.
REQ-012 pipe_flush_o  out  1  flush to every ALU stage.
REQ-013 result_valid_i  in  1  last ALU stage produces a result.
REQ-014 result_i  in  alu_result_t  result payload.
REQ-015 commit_valid_o  out  1  result offered to commit.
REQ-016 commit_result_o  out  alu_result_t  FIFO head.
REQ-017 commit_ready_i  in  1  commit accepts the result.
REQ-018 credits_o  out  $clog2(FIFO_DEPTH+1)  free credits (debug).

Function
REQ-019 Fire SHALL be defined as alu_valid_i & alu_ready_o.
REQ-020 alu_ready_o SHALL be combinational and equal to (state==RUN) & (credits>0) & ~flush_req.
REQ-021 setup_valid_o SHALL equal fire; setup_alu_data SHALL equal in_alu_data, combinationally with zero added latency.
REQ-022 credits SHALL reset to FIFO_DEPTH and update as follows:
- -1 on fire.
- +1 on pop (commit_valid_o & commit_ready_i).
- Unchanged when fire and pop occur in the same cycle.
- Never below 0 or above FIFO_DEPTH.
REQ-023 The ALU pipeline SHALL never be back-pressured; because of the credit scheme, a push never finds the FIFO full, and the ALU stage stall inputs are tied 0.
REQ-024 Push SHALL occur when result_valid_i & (state==RUN) & ~flush_req; the FIFO SHALL be first-in, first-out.
REQ-025 commit_valid_o SHALL equal ~fifo_empty & (state==RUN) & ~flush_req, and commit_result_o SHALL be the FIFO head; there is no bypass, so a result pushed in cycle N is first visible in cycle N+1.
REQ-026 A simultaneous push and pop on a non-empty FIFO SHALL leave occupancy unchanged; on an empty FIFO, the push SHALL complete and no pop SHALL occur.
REQ-027 The FSM SHALL have two states, RUN and FLUSH.
- RUN goes to FLUSH when flush_req is sampled high.
- FLUSH goes to RUN in the cycle after flush_cnt==1 with flush_req low.
REQ-028 On a sampled flush_req, in any state, the block SHALL:
- load flush_cnt with ALU_STAGES;
- clear the FIFO;
- set credits to FIFO_DEPTH.
The flush SHALL override any push, pop or fire in the same cycle.
REQ-029 In FLUSH, flush_cnt SHALL decrement every cycle; a new flush_req in FLUSH SHALL reload it to ALU_STAGES.
REQ-030 pipe_flush_o SHALL equal flush_req | (state==FLUSH).
REQ-031 In FLUSH, result_valid_i SHALL be ignored, and alu_ready_o and commit_valid_o SHALL be 0.

Reset
REQ-032 Asserting rst_core_n low SHALL asynchronously set:
- state to FLUSH and flush_cnt to ALU_STAGES;
- the FIFO to empty;
- credits to FIFO_DEPTH.
REQ-033 During reset and for ALU_STAGES cycles after rst_core_n is released, the outputs SHALL be alu_ready_o=0, setup_valid_o=0, commit_valid_o=0, pipe_flush_o=1 and credits_o=FIFO_DEPTH; this drains the unreset pipeline registers.
REQ-034 The FIFO payload storage SHALL not be reset; only the pointers and count are reset.

Structure
REQ-035 alu_data_t, alu_result_t and the ALU_STAGES default SHALL reside in hsv_core_pkg; the FSM state enum SHALL be local to the module.
REQ-036 The FIFO SHALL be a sub-module, hsv_core_alu_result_fifo, with push, pop, synchronous clear, empty and full ports.
REQ-037 The implementation SHALL contain assertions that credits stays within 0..FIFO_DEPTH and that no push occurs while the FIFO is full.

Verification
REQ-038 Reset release: count cycles with pipe_flush_o=1 after rst_core_n rises; required exactly 3, then alu_ready_o=1 with credits_o=4.
REQ-039 Credit exhaustion: issue 4 ops with commit_ready_i=0; required credits_o=0, alu_ready_o=0, and after 3 cycles FIFO holds 4 results with commit_valid_o=1 and no overflow.
REQ-040 Credit recovery: with 0 credits, pop one result; required credits_o=1 and alu_ready_o=1 in the next cycle; then fire and pop together; required credits_o unchanged.
REQ-041 Ordering: stream results 0xA..0xD with random commit_ready_i; required commit order A, B, C, D and each result visible one cycle after result_valid_i.
REQ-042 Mid-flight flush: pulse flush_req with 2 ops in flight and 2 queued; required:
- FIFO emptied and credits_o=4;
- late result_valid_i pulses dropped;
- pipe_flush_o high for 1+3 cycles;
- alu_ready_o low for the same 1+3 cycles.
REQ-043 Back-to-back flush: pulse flush_req again while flush_cnt=1; required flush_cnt reloaded to 3 and RUN entered only after 3 more cycles.
